// File: rtl/timer_alarm_pkg.sv
// ============================================================================
// timer_alarm_pkg : command codes, default widths and slot type for the
//                   multi-channel alarm scheduler.   Rev 1.0
// ============================================================================
`default_nettype none

package timer_alarm_pkg;

    localparam int TAS_TV_W  = 64;
    localparam int TAS_PER_W = 32;

    localparam logic [1:0] CMD_ARM    = 2'd0;
    localparam logic [1:0] CMD_DISARM = 2'd1;
    localparam logic [1:0] CMD_ACK    = 2'd2;
    localparam logic [1:0] CMD_RSVD   = 2'd3;

    typedef struct packed {
        logic [TAS_TV_W-1:0]  cmp;
        logic [TAS_PER_W-1:0] period;
    } alarm_slot_t;

endpackage

`default_nettype wire

// File: rtl/timer_alarm_eval.sv
// ============================================================================
// timer_alarm_eval : shared compare / reload-add datapath for one slot.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module timer_alarm_eval #(
    parameter int TV_W  = 64,
    parameter int PER_W = 32
) (
    input  logic [TV_W-1:0]  tv_i,
    input  logic [TV_W-1:0]  cmp_i,
    input  logic [PER_W-1:0] period_i,
    output logic             fire_o,
    output logic [TV_W-1:0]  next_cmp_o,
    output logic             overflow_o
);

    logic [TV_W:0] w_sum;

    // One extra bit holds the carry out of the reload addition.
    assign w_sum      = {1'b0, cmp_i} + {{(TV_W - PER_W + 1){1'b0}}, period_i};
    assign fire_o     = (tv_i >= cmp_i);
    assign next_cmp_o = w_sum[TV_W-1:0];
    assign overflow_o = w_sum[TV_W];

endmodule

`default_nettype wire

// File: rtl/timer_alarm_sched.sv
// ============================================================================
// timer_alarm_sched : N-channel alarm scheduler with round-robin evaluation
//                     of one slot per cycle.   Rev 1.0
// ============================================================================
`default_nettype none

module timer_alarm_sched
    import timer_alarm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int TV_W  = TAS_TV_W,
    parameter int PER_W = TAS_PER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TV_W-1:0]  timer_value,
    input  logic             timer_enable,
    input  logic             cfg_valid,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_cmd,
    input  logic [TV_W-1:0]  cfg_cmp,
    input  logic [PER_W-1:0] cfg_period,
    output logic [N_CH-1:0]  armed,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  ovf,
    output logic             irq,
    output logic [CH_W-1:0]  scan_ch
);

    alarm_slot_t     slot_q [N_CH];
    alarm_slot_t     slot_d [N_CH];
    logic [N_CH-1:0] armed_q, armed_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [CH_W-1:0] scan_q, scan_d;
    logic            irq_q;

    logic            w_fire;
    logic            w_ovf;
    logic [TV_W-1:0] w_next_cmp;
    logic            w_cfg_hit;

    generate
        if (N_CH == (1 << CH_W)) begin : g_full_range
            assign w_cfg_hit = cfg_valid;
        end else begin : g_partial_range
            assign w_cfg_hit = cfg_valid && (cfg_ch < CH_W'(N_CH));
        end
    endgenerate

    timer_alarm_eval #(
        .TV_W  (TV_W),
        .PER_W (PER_W)
    ) u_eval (
        .tv_i       (timer_value),
        .cmp_i      (slot_q[scan_q].cmp),
        .period_i   (slot_q[scan_q].period),
        .fire_o     (w_fire),
        .next_cmp_o (w_next_cmp),
        .overflow_o (w_ovf)
    );

    always_comb begin
        armed_d   = armed_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        slot_d    = slot_q;
        scan_d    = scan_q;

        if (timer_enable) begin
            scan_d = (scan_q == CH_W'(N_CH - 1)) ? '0 : scan_q + 1'b1;
        end

        if (timer_enable && armed_q[scan_q] && w_fire) begin
            pending_d[scan_q] = 1'b1;
            if (slot_q[scan_q].period == '0) begin
                armed_d[scan_q] = 1'b0;
            end else if (w_ovf) begin
                armed_d[scan_q] = 1'b0;
                ovf_d[scan_q]   = 1'b1;
            end else begin
                slot_d[scan_q].cmp = w_next_cmp;
            end
        end

        // A command discards any scan update made to the same channel.
        if (w_cfg_hit) begin
            armed_d[cfg_ch]   = armed_q[cfg_ch];
            pending_d[cfg_ch] = pending_q[cfg_ch];
            ovf_d[cfg_ch]     = ovf_q[cfg_ch];
            slot_d[cfg_ch]    = slot_q[cfg_ch];
            case (cfg_cmd)
                CMD_ARM: begin
                    slot_d[cfg_ch].cmp    = cfg_cmp;
                    slot_d[cfg_ch].period = cfg_period;
                    armed_d[cfg_ch]       = 1'b1;
                    ovf_d[cfg_ch]         = 1'b0;
                end
                CMD_DISARM: armed_d[cfg_ch] = 1'b0;
                CMD_ACK: begin
                    pending_d[cfg_ch] = 1'b0;
                    ovf_d[cfg_ch]     = 1'b0;
                end
                CMD_RSVD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                slot_q[i] <= '0;
            end
            armed_q   <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            scan_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            armed_q   <= armed_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            scan_q    <= scan_d;
            irq_q     <= |pending_q;
        end
    end

    assign armed   = armed_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;
    assign irq     = irq_q;
    assign scan_ch = scan_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_alarm_sched.sv
// ============================================================================
// tb_timer_alarm_sched : directed scenarios plus random traffic against a
//                        behavioural alarm model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_timer_alarm_sched;

    localparam int N = 4;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        cv  = 1'b0;
    logic [1:0]  cch = '0;
    logic [1:0]  ccmd = '0;
    logic [63:0] tv = '0;
    logic [63:0] ccmp = '0;
    logic [31:0] cper = '0;

    logic [3:0]  armed, pending, ovf;
    logic        irq;
    logic [1:0]  scan_ch;

    // Behavioural model state
    logic [63:0] m_cmp [N];
    logic [31:0] m_per [N];
    logic [3:0]  m_armed, m_pend, m_ovf;
    logic        m_irq;
    int          m_scan;

    int vectors = 0;
    int miscompares = 0;

    timer_alarm_sched #(.N_CH(4), .CH_W(2), .TV_W(64), .PER_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .timer_value  (tv),
        .timer_enable (en),
        .cfg_valid    (cv),
        .cfg_ch       (cch),
        .cfg_cmd      (ccmd),
        .cfg_cmp      (ccmp),
        .cfg_period   (cper),
        .armed        (armed),
        .pending      (pending),
        .ovf          (ovf),
        .irq          (irq),
        .scan_ch      (scan_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies the alarm rules for one clock edge using the currently driven inputs.
    task automatic model_edge();
        int          c;
        logic [64:0] sum;
        logic        irq_next;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cmp[i] = '0;
                m_per[i] = '0;
            end
            m_armed = '0; m_pend = '0; m_ovf = '0; m_irq = 1'b0; m_scan = 0;
            return;
        end
        irq_next = (m_pend != 4'b0);
        c = m_scan;
        if (en && !(cv && int'(cch) == c) && m_armed[c] && tv >= m_cmp[c]) begin
            m_pend[c] = 1'b1;
            sum = {1'b0, m_cmp[c]} + 65'(m_per[c]);
            if (m_per[c] == 0) m_armed[c] = 1'b0;
            else if (sum > 65'(TOP)) begin
                m_armed[c] = 1'b0;
                m_ovf[c]   = 1'b1;
            end else m_cmp[c] = sum[63:0];
        end
        if (cv) begin
            case (ccmd)
                2'd0: begin
                    m_cmp[cch] = ccmp; m_per[cch] = cper;
                    m_armed[cch] = 1'b1; m_ovf[cch] = 1'b0;
                end
                2'd1: m_armed[cch] = 1'b0;
                2'd2: begin m_pend[cch] = 1'b0; m_ovf[cch] = 1'b0; end
                default: ;
            endcase
        end
        if (en) m_scan = (m_scan + 1) % N;
        m_irq = irq_next;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("armed",   64'(armed),   64'(m_armed));
        chk("pending", 64'(pending), 64'(m_pend));
        chk("ovf",     64'(ovf),     64'(m_ovf));
        chk("irq",     64'(irq),     64'(m_irq));
        chk("scan_ch", 64'(scan_ch), 64'(m_scan));
        cv  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [1:0] cmd,
                       input logic [63:0] cmp, input logic [31:0] per);
        cv = 1'b1; cch = ch; ccmd = cmd; ccmp = cmp; cper = per;
        step();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        en = 1'b1;
        reset_pulse();
        reset_pulse();
        chk("rst_scan", 64'(scan_ch), 64'd0);

        // 1. One-shot
        tv = 64'd90;
        cfg(2'd1, 2'd0, 64'd100, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tv = 64'd90 + 64'(k);
            step();
        end
        chk("t1_pend1",  64'(pending[1]), 64'd1);
        chk("t1_armed1", 64'(armed[1]),   64'd0);
        chk("t1_irq",    64'(irq),        64'd1);
        cfg(2'd1, 2'd2, 64'd0, 32'd0);
        chk("t1_ack_pend", 64'(pending[1]), 64'd0);
        step();
        chk("t1_ack_irq", 64'(irq), 64'd0);

        // 2. Periodic
        reset_pulse();
        tv = 64'd0;
        cfg(2'd2, 2'd0, 64'd50, 32'd20);
        for (int t = 0; t <= 200; t++) begin
            tv = 64'(t);
            if (m_pend[2]) begin
                cv = 1'b1; cch = 2'd2; ccmd = 2'd2;
            end
            step();
        end
        if (m_pend[2]) cfg(2'd2, 2'd2, 64'd0, 32'd0);
        tv = 64'd209;
        for (int k = 0; k < 6; k++) step();
        chk("t2_no_fire_209", 64'(pending[2]), 64'd0);
        tv = 64'd210;
        for (int k = 0; k < 5; k++) step();
        chk("t2_fire_210", 64'(pending[2]), 64'd1);
        chk("t2_armed2",   64'(armed[2]),   64'd1);

        // 3. Reload overflow
        reset_pulse();
        tv = TOP - 64'd4;
        cfg(2'd0, 2'd0, TOP - 64'd4, 32'd10);
        for (int k = 0; k < 4; k++) step();
        chk("t3_pend0",  64'(pending[0]), 64'd1);
        chk("t3_ovf0",   64'(ovf[0]),     64'd1);
        chk("t3_armed0", 64'(armed[0]),   64'd0);

        // 4. Collision: DISARM while channel 3 is being scanned and would fire
        reset_pulse();
        tv = 64'd1000;
        en = 1'b0;
        cfg(2'd3, 2'd0, 64'd0, 32'd0);
        en = 1'b1;
        for (int k = 0; k < 8 && m_scan != 3; k++) step();
        chk("t4_reach_scan3", 64'(scan_ch), 64'd3);
        cfg(2'd3, 2'd1, 64'd0, 32'd0);
        chk("t4_pend3",  64'(pending[3]), 64'd0);
        chk("t4_armed3", 64'(armed[3]),   64'd0);
        chk("t4_scan0",  64'(scan_ch),    64'd0);
        for (int k = 0; k < 4; k++) step();

        // 5. Pause then immediate fire
        reset_pulse();
        en = 1'b0;
        tv = 64'd5;
        cfg(2'd0, 2'd0, 64'd0, 32'd0);
        for (int k = 0; k < 5; k++) step();
        chk("t5_frozen_scan", 64'(scan_ch), 64'd0);
        chk("t5_no_pend",     64'(pending), 64'd0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t5_pend0", 64'(pending[0]), 64'd1);

        // 6. Reset mid-operation
        reset_pulse();
        tv = 64'd100;
        for (int c = 0; c < N; c++) cfg(2'(c), 2'd0, 64'd0, 32'd1);
        for (int k = 0; k < 6; k++) step();
        chk("t6_pend_all", 64'(pending), 64'hF);
        reset_pulse();
        chk("t6_armed", 64'(armed),   64'd0);
        chk("t6_pend",  64'(pending), 64'd0);
        chk("t6_irq",   64'(irq),     64'd0);
        chk("t6_scan",  64'(scan_ch), 64'd0);
        for (int k = 0; k < 8; k++) step();
        chk("t6_quiet", 64'(pending), 64'd0);

        // Random traffic, with a late phase close to the top of the range
        tv = 64'd0;
        for (int k = 0; k < 600; k++) begin
            if (k == 400) tv = TOP - 64'd300;
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cv   = 1'b1;
                cch  = 2'($urandom_range(0, 3));
                ccmd = 2'($urandom_range(0, 3));
                ccmp = tv + 64'($urandom_range(0, 40));
                cper = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) ccmp = TOP - 64'($urandom_range(0, 20));
            end
            step();
            tv = tv + 64'($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
